// File: rtl/mem_wb_pkg.sv
// Shared types and the exception-vector decode table for the MEM->WB stage.
// The exception bit index doubles as its priority: bit 0 wins over every other bit.
package mem_wb_pkg;

   localparam int EXCP_IDX_W = 4;

   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_PIL  = 6'h01;
   localparam logic [5:0] ECODE_PIS  = 6'h02;
   localparam logic [5:0] ECODE_PIF  = 6'h03;
   localparam logic [5:0] ECODE_PME  = 6'h04;
   localparam logic [5:0] ECODE_PPI  = 6'h07;
   localparam logic [5:0] ECODE_ADE  = 6'h08;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_SYS  = 6'h0B;
   localparam logic [5:0] ECODE_BRK  = 6'h0C;
   localparam logic [5:0] ECODE_INE  = 6'h0D;
   localparam logic [5:0] ECODE_IPE  = 6'h0E;
   localparam logic [5:0] ECODE_TLBR = 6'h3F;

   localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
   localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

   typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

   typedef enum logic [1:0] {VA_NONE = 2'd0, VA_PC = 2'd1, VA_VADDR = 2'd2} va_src_e;

   typedef struct packed {
      logic [5:0] ecode;
      logic [8:0] esubcode;
      va_src_e    va_src;
      logic       tlb;
      logic       tlbrefill;
   } excp_info_t;

   // Per-lane writeback permissions after trap masking.
   typedef struct packed {
      logic wreg;
      logic csr_we;
      logic llbit_we;
      logic commit;
   } lane_ctl_t;

   function automatic excp_info_t excp_decode(input logic [EXCP_IDX_W-1:0] idx);
      excp_info_t r;
      r = '0;
      case (idx)
         4'd0:  r.ecode = ECODE_INT;
         4'd1:  r.ecode = ECODE_ADE;
         4'd2:  r.ecode = ECODE_TLBR;
         4'd3:  r.ecode = ECODE_PIF;
         4'd4:  r.ecode = ECODE_PPI;
         4'd5:  r.ecode = ECODE_SYS;
         4'd6:  r.ecode = ECODE_BRK;
         4'd7:  r.ecode = ECODE_INE;
         4'd8:  r.ecode = ECODE_IPE;
         4'd9:  r.ecode = ECODE_ALE;
         4'd10: r.ecode = ECODE_ADE;
         4'd11: r.ecode = ECODE_TLBR;
         4'd12: r.ecode = ECODE_PME;
         4'd13: r.ecode = ECODE_PPI;
         4'd14: r.ecode = ECODE_PIS;
         4'd15: r.ecode = ECODE_PIL;
      endcase
      if (idx == 4'd1)  r.esubcode = ESUBCODE_ADEF;
      if (idx == 4'd10) r.esubcode = ESUBCODE_ADEM;
      if (idx inside {[4'd1:4'd4]})       r.va_src = VA_PC;
      else if (idx inside {[4'd9:4'd15]}) r.va_src = VA_VADDR;
      r.tlb       = idx inside {4'd2, 4'd3, 4'd4, [4'd11:4'd15]};
      r.tlbrefill = (idx == 4'd2) || (idx == 4'd11);
      return r;
   endfunction

endpackage

// File: rtl/excp_prio_enc.sv
// Lowest-set-bit encoder for one lane's exception vector.
module excp_prio_enc #(
   parameter int W     = 16,
   parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]     vec_i,
   output logic [IDX_W-1:0] idx_o
);

   always_comb begin
      // NOTE: assign a default before any conditional write so no latch is inferred.
      idx_o = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec_i[i]) idx_o = IDX_W'(i);
      end
   end

endmodule

// File: rtl/mem_wb_bundle.sv
// MEM->WB pipeline register for an N-lane in-order core: trap masking, registered
// exception record, post-trap drain until flush, and a retired-instruction counter.
module mem_wb_bundle
   import mem_wb_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int DATA_W = 32,
   parameter int EXCP_W = 16,
   parameter int CNT_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic                    stall_i,
   input  logic [LANES-1:0]        mem_valid_i,
   input  logic [LANES*DATA_W-1:0] mem_pc_i,
   input  logic [LANES*DATA_W-1:0] mem_instr_i,
   input  logic [LANES-1:0]        mem_wreg_i,
   input  logic [LANES*5-1:0]      mem_wd_i,
   input  logic [LANES*DATA_W-1:0] mem_wdata_i,
   input  logic [LANES-1:0]        mem_csr_we_i,
   input  logic [LANES*14-1:0]     mem_csr_addr_i,
   input  logic [LANES*DATA_W-1:0] mem_csr_data_i,
   input  logic [LANES-1:0]        mem_llbit_we_i,
   input  logic [LANES-1:0]        mem_llbit_value_i,
   input  logic [LANES-1:0]        mem_excp_i,
   input  logic [LANES*EXCP_W-1:0] mem_excp_num_i,
   input  logic [LANES-1:0]        mem_ertn_i,
   input  logic [LANES*DATA_W-1:0] mem_vaddr_i,
   output logic [LANES-1:0]        wb_wreg_o,
   output logic [LANES*5-1:0]      wb_wd_o,
   output logic [LANES*DATA_W-1:0] wb_wdata_o,
   output logic [LANES-1:0]        wb_csr_we_o,
   output logic [LANES*14-1:0]     wb_csr_addr_o,
   output logic [LANES*DATA_W-1:0] wb_csr_data_o,
   output logic [LANES-1:0]        wb_llbit_we_o,
   output logic [LANES-1:0]        wb_llbit_value_o,
   output logic [LANES-1:0]        debug_commit_valid_o,
   output logic [LANES*DATA_W-1:0] debug_commit_pc_o,
   output logic [LANES*DATA_W-1:0] debug_commit_instr_o,
   output logic                    excp_flush_o,
   output logic                    ertn_flush_o,
   output logic [DATA_W-1:0]       csr_era_o,
   output logic [DATA_W-1:0]       bad_va_o,
   output logic [5:0]              csr_ecode_o,
   output logic [8:0]              csr_esubcode_o,
   output logic                    va_error_o,
   output logic                    excp_tlb_o,
   output logic                    excp_tlbrefill_o,
   output logic [18:0]             excp_tlb_vppn_o,
   output logic [CNT_W-1:0]        commit_cnt_o
);

   localparam int IDX_W = (EXCP_W > 1) ? $clog2(EXCP_W) : 1;

   state_e                  state_q, state_d;
   logic [LANES-1:0]        wreg_q, wreg_d, csr_we_q, csr_we_d, llbit_we_q, llbit_we_d;
   logic [LANES-1:0]        llbit_value_q, llbit_value_d, commit_q, commit_d;
   logic [LANES*5-1:0]      wd_q, wd_d;
   logic [LANES*14-1:0]     csr_addr_q, csr_addr_d;
   logic [LANES*DATA_W-1:0] wdata_q, wdata_d, csr_data_q, csr_data_d;
   logic [LANES*DATA_W-1:0] cpc_q, cpc_d, cinstr_q, cinstr_d;
   logic                    excp_flush_q, excp_flush_d, ertn_flush_q, ertn_flush_d;
   logic [DATA_W-1:0]       era_q, era_d, bad_va_q, bad_va_d;
   logic [5:0]              ecode_q, ecode_d;
   logic [8:0]              esubcode_q, esubcode_d;
   logic                    va_error_q, va_error_d, tlb_q, tlb_d, tlbrefill_q, tlbrefill_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic [IDX_W-1:0]        excp_idx [LANES];
   lane_ctl_t               lane_ctl [LANES];
   logic                    seen, trap_excp, trap_ertn;
   logic [DATA_W-1:0]       trap_pc, trap_vaddr;
   excp_info_t              trap_info;
   logic [CNT_W-1:0]        commit_num;

   for (genvar g = 0; g < LANES; g++) begin : g_enc
      excp_prio_enc #(.W(EXCP_W), .IDX_W(IDX_W)) u_enc (
         .vec_i (mem_excp_num_i[g*EXCP_W +: EXCP_W]),
         .idx_o (excp_idx[g])
      );
   end

   // Oldest-first scan: the first valid trapping lane stops every younger lane.
   always_comb begin
      seen       = 1'b0;
      trap_excp  = 1'b0;
      trap_ertn  = 1'b0;
      trap_pc    = '0;
      trap_vaddr = '0;
      trap_info  = '0;
      commit_num = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_ctl[i] = '0;
         if (mem_valid_i[i] && !seen) begin
            if (mem_excp_i[i]) begin
               seen       = 1'b1;
               trap_excp  = 1'b1;
               trap_pc    = mem_pc_i[i*DATA_W +: DATA_W];
               trap_vaddr = mem_vaddr_i[i*DATA_W +: DATA_W];
               trap_info  = excp_decode(EXCP_IDX_W'(excp_idx[i]));
            end else if (mem_ertn_i[i]) begin
               seen               = 1'b1;
               trap_ertn          = 1'b1;
               lane_ctl[i].commit = 1'b1;
            end else begin
               lane_ctl[i].wreg     = mem_wreg_i[i];
               lane_ctl[i].csr_we   = mem_csr_we_i[i];
               lane_ctl[i].llbit_we = mem_llbit_we_i[i];
               lane_ctl[i].commit   = 1'b1;
            end
         end
         if (lane_ctl[i].commit) commit_num = commit_num + CNT_W'(1);
      end
   end

   always_comb begin
      state_d       = state_q;
      wreg_d        = wreg_q;
      csr_we_d      = csr_we_q;
      llbit_we_d    = llbit_we_q;
      llbit_value_d = llbit_value_q;
      wd_d          = wd_q;
      wdata_d       = wdata_q;
      csr_addr_d    = csr_addr_q;
      csr_data_d    = csr_data_q;
      cpc_d         = cpc_q;
      cinstr_d      = cinstr_q;
      cnt_d         = cnt_q;
      commit_d      = '0;
      excp_flush_d  = 1'b0;
      ertn_flush_d  = 1'b0;
      era_d         = '0;
      bad_va_d      = '0;
      ecode_d       = '0;
      esubcode_d    = '0;
      va_error_d    = 1'b0;
      tlb_d         = 1'b0;
      tlbrefill_d   = 1'b0;

      if (flush_i) begin
         state_d    = ST_RUN;
         wreg_d     = '0;
         csr_we_d   = '0;
         llbit_we_d = '0;
      end else if (!stall_i) begin
         wreg_d     = '0;
         csr_we_d   = '0;
         llbit_we_d = '0;
         if (state_q == ST_RUN) begin
            for (int i = 0; i < LANES; i++) begin
               wreg_d[i]     = lane_ctl[i].wreg;
               csr_we_d[i]   = lane_ctl[i].csr_we;
               llbit_we_d[i] = lane_ctl[i].llbit_we;
               commit_d[i]   = lane_ctl[i].commit;
            end
            llbit_value_d = mem_llbit_value_i;
            wd_d          = mem_wd_i;
            wdata_d       = mem_wdata_i;
            csr_addr_d    = mem_csr_addr_i;
            csr_data_d    = mem_csr_data_i;
            cpc_d         = mem_pc_i;
            cinstr_d      = mem_instr_i;
            cnt_d         = cnt_q + commit_num;
            if (trap_excp) begin
               state_d      = ST_DRAIN;
               excp_flush_d = 1'b1;
               era_d        = trap_pc;
               ecode_d      = trap_info.ecode;
               esubcode_d   = trap_info.esubcode;
               tlb_d        = trap_info.tlb;
               tlbrefill_d  = trap_info.tlbrefill;
               case (trap_info.va_src)
                  VA_PC:    begin bad_va_d = trap_pc;    va_error_d = 1'b1; end
                  VA_VADDR: begin bad_va_d = trap_vaddr; va_error_d = 1'b1; end
                  default:  ;
               endcase
            end else if (trap_ertn) begin
               state_d      = ST_DRAIN;
               ertn_flush_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: data registers are reset too, because every output must read 0 after reset.
      if (rst) begin
         state_q       <= ST_RUN;
         wreg_q        <= '0;
         csr_we_q      <= '0;
         llbit_we_q    <= '0;
         llbit_value_q <= '0;
         wd_q          <= '0;
         wdata_q       <= '0;
         csr_addr_q    <= '0;
         csr_data_q    <= '0;
         cpc_q         <= '0;
         cinstr_q      <= '0;
         commit_q      <= '0;
         excp_flush_q  <= 1'b0;
         ertn_flush_q  <= 1'b0;
         era_q         <= '0;
         bad_va_q      <= '0;
         ecode_q       <= '0;
         esubcode_q    <= '0;
         va_error_q    <= 1'b0;
         tlb_q         <= 1'b0;
         tlbrefill_q   <= 1'b0;
         cnt_q         <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q       <= state_d;
         wreg_q        <= wreg_d;
         csr_we_q      <= csr_we_d;
         llbit_we_q    <= llbit_we_d;
         llbit_value_q <= llbit_value_d;
         wd_q          <= wd_d;
         wdata_q       <= wdata_d;
         csr_addr_q    <= csr_addr_d;
         csr_data_q    <= csr_data_d;
         cpc_q         <= cpc_d;
         cinstr_q      <= cinstr_d;
         commit_q      <= commit_d;
         excp_flush_q  <= excp_flush_d;
         ertn_flush_q  <= ertn_flush_d;
         era_q         <= era_d;
         bad_va_q      <= bad_va_d;
         ecode_q       <= ecode_d;
         esubcode_q    <= esubcode_d;
         va_error_q    <= va_error_d;
         tlb_q         <= tlb_d;
         tlbrefill_q   <= tlbrefill_d;
         cnt_q         <= cnt_d;
      end
   end

   assign wb_wreg_o            = wreg_q;
   assign wb_wd_o              = wd_q;
   assign wb_wdata_o           = wdata_q;
   assign wb_csr_we_o          = csr_we_q;
   assign wb_csr_addr_o        = csr_addr_q;
   assign wb_csr_data_o        = csr_data_q;
   assign wb_llbit_we_o        = llbit_we_q;
   assign wb_llbit_value_o     = llbit_value_q;
   assign debug_commit_valid_o = commit_q;
   assign debug_commit_pc_o    = cpc_q;
   assign debug_commit_instr_o = cinstr_q;
   assign excp_flush_o         = excp_flush_q;
   assign ertn_flush_o         = ertn_flush_q;
   assign csr_era_o            = era_q;
   assign bad_va_o             = bad_va_q;
   assign csr_ecode_o          = ecode_q;
   assign csr_esubcode_o       = esubcode_q;
   assign va_error_o           = va_error_q;
   assign excp_tlb_o           = tlb_q;
   assign excp_tlbrefill_o     = tlbrefill_q;
   assign excp_tlb_vppn_o      = bad_va_q[31:13];
   assign commit_cnt_o         = cnt_q;

endmodule

// File: tb/tb_mem_wb_bundle.sv
// Directed bench for mem_wb_bundle (2 lanes): expected records are queued per step
// and popped/compared one cycle later, after the capturing clock edge.
module tb_mem_wb_bundle;

   localparam int LANES = 2;
   localparam int DW    = 32;
   localparam int EW    = 16;
   localparam int CW    = 32;

   logic clk = 1'b0;
   logic rst, flush, stall;
   logic [LANES-1:0]    mem_valid, mem_wreg, mem_csr_we, mem_llbit_we, mem_llbit_value, mem_excp, mem_ertn;
   logic [LANES*DW-1:0] mem_pc, mem_instr, mem_wdata, mem_csr_data, mem_vaddr;
   logic [LANES*5-1:0]  mem_wd;
   logic [LANES*14-1:0] mem_csr_addr;
   logic [LANES*EW-1:0] mem_excp_num;

   logic [LANES-1:0]    wb_wreg, wb_csr_we, wb_llbit_we, wb_llbit_value, commit_valid;
   logic [LANES*5-1:0]  wb_wd;
   logic [LANES*14-1:0] wb_csr_addr;
   logic [LANES*DW-1:0] wb_wdata, wb_csr_data, commit_pc, commit_instr;
   logic                excp_flush, ertn_flush, va_error, excp_tlb, excp_tlbrefill;
   logic [DW-1:0]       csr_era, bad_va;
   logic [5:0]          csr_ecode;
   logic [8:0]          csr_esubcode;
   logic [18:0]         vppn;
   logic [CW-1:0]       commit_cnt;

   mem_wb_bundle #(.LANES(LANES), .DATA_W(DW), .EXCP_W(EW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall),
      .mem_valid_i(mem_valid), .mem_pc_i(mem_pc), .mem_instr_i(mem_instr),
      .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
      .mem_csr_we_i(mem_csr_we), .mem_csr_addr_i(mem_csr_addr), .mem_csr_data_i(mem_csr_data),
      .mem_llbit_we_i(mem_llbit_we), .mem_llbit_value_i(mem_llbit_value),
      .mem_excp_i(mem_excp), .mem_excp_num_i(mem_excp_num), .mem_ertn_i(mem_ertn),
      .mem_vaddr_i(mem_vaddr),
      .wb_wreg_o(wb_wreg), .wb_wd_o(wb_wd), .wb_wdata_o(wb_wdata),
      .wb_csr_we_o(wb_csr_we), .wb_csr_addr_o(wb_csr_addr), .wb_csr_data_o(wb_csr_data),
      .wb_llbit_we_o(wb_llbit_we), .wb_llbit_value_o(wb_llbit_value),
      .debug_commit_valid_o(commit_valid), .debug_commit_pc_o(commit_pc),
      .debug_commit_instr_o(commit_instr),
      .excp_flush_o(excp_flush), .ertn_flush_o(ertn_flush),
      .csr_era_o(csr_era), .bad_va_o(bad_va), .csr_ecode_o(csr_ecode),
      .csr_esubcode_o(csr_esubcode), .va_error_o(va_error), .excp_tlb_o(excp_tlb),
      .excp_tlbrefill_o(excp_tlbrefill), .excp_tlb_vppn_o(vppn), .commit_cnt_o(commit_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  wreg, csr_we, commit;
      logic [63:0] wdata, wmask;
      logic        xf, ef, rec, va_err, tlb, refill;
      logic [5:0]  ecode;
      logic [8:0]  esub;
      logic [31:0] bad_va, era, cnt;
      logic [18:0] vppn;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   step_no  = 0;

   function automatic exp_t blank();
      exp_t r;
      r = '{default: '0};
      r.rec = 1'b1;
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL step%0d %s: observed %0h expected %0h", step_no, tag, obs, exp);
      end
   endtask

   task automatic clr();
      flush = 1'b0; stall = 1'b0;
      mem_valid = '0; mem_wreg = '0; mem_csr_we = '0; mem_llbit_we = '0;
      mem_llbit_value = '0; mem_excp = '0; mem_ertn = '0;
      mem_pc = '0; mem_instr = '0; mem_wdata = '0; mem_csr_data = '0; mem_vaddr = '0;
      mem_wd = '0; mem_csr_addr = '0; mem_excp_num = '0;
   endtask

   task automatic lane(input int i, input logic [31:0] pc, input logic [31:0] wdata,
                       input logic csr, input logic [15:0] xnum, input logic ertn,
                       input logic [31:0] vaddr);
      mem_valid[i]            = 1'b1;
      mem_pc[i*DW +: DW]      = pc;
      mem_instr[i*DW +: DW]   = ~pc;
      mem_wreg[i]             = 1'b1;
      mem_wd[i*5 +: 5]        = 5'(i + 1);
      mem_wdata[i*DW +: DW]   = wdata;
      mem_csr_we[i]           = csr;
      mem_csr_addr[i*14 +: 14] = 14'h6;
      mem_csr_data[i*DW +: DW] = wdata;
      mem_excp[i]             = |xnum;
      mem_excp_num[i*EW +: EW] = xnum;
      mem_ertn[i]             = ertn;
      mem_vaddr[i*DW +: DW]   = vaddr;
   endtask

   task automatic tick();
      exp_t x;
      @(posedge clk);
      #1;
      step_no++;
      if (sb.size() == 0) begin
         n_assert++; n_fail++;
         $error("FAIL step%0d scoreboard: observed empty queue expected entry", step_no);
         return;
      end
      x = sb.pop_front();
      check("wb_wreg",      64'(wb_wreg),      64'(x.wreg));
      check("wb_csr_we",    64'(wb_csr_we),    64'(x.csr_we));
      check("commit_valid", 64'(commit_valid), 64'(x.commit));
      check("excp_flush",   64'(excp_flush),   64'(x.xf));
      check("ertn_flush",   64'(ertn_flush),   64'(x.ef));
      check("commit_cnt",   64'(commit_cnt),   64'(x.cnt));
      if (x.wmask != '0) check("wb_wdata", wb_wdata & x.wmask, x.wdata);
      if (x.rec) begin
         check("csr_ecode",      64'(csr_ecode),      64'(x.ecode));
         check("csr_esubcode",   64'(csr_esubcode),   64'(x.esub));
         check("bad_va",         64'(bad_va),         64'(x.bad_va));
         check("va_error",       64'(va_error),       64'(x.va_err));
         check("excp_tlb",       64'(excp_tlb),       64'(x.tlb));
         check("excp_tlbrefill", 64'(excp_tlbrefill), 64'(x.refill));
         check("excp_tlb_vppn",  64'(vppn),           64'(x.vppn));
         check("csr_era",        64'(csr_era),        64'(x.era));
      end
   endtask

   initial begin
      // Reset: every output zero.
      rst = 1'b1; clr();
      e = blank(); sb.push_back(e); tick();

      // Two normal lanes, lane1 also writes a CSR.
      @(negedge clk); rst = 1'b0; clr();
      lane(0, 32'h1000, 32'h11, 1'b0, 16'h0, 1'b0, 32'h0);
      lane(1, 32'h1004, 32'h22, 1'b1, 16'h0, 1'b0, 32'h0);
      e = blank(); e.wreg = 2'b11; e.csr_we = 2'b10; e.commit = 2'b11; e.cnt = 2;
      e.wdata = 64'h0000_0022_0000_0011; e.wmask = '1;
      sb.push_back(e); tick();

      // Stall for three cycles: data and enables held, no commit, counter frozen.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); clr(); stall = 1'b1;
         lane(0, 32'h1008, 32'h33, 1'b0, 16'h0, 1'b0, 32'h0);
         lane(1, 32'h100C, 32'h44, 1'b1, 16'h0, 1'b0, 32'h0);
         e = blank(); e.wreg = 2'b11; e.csr_we = 2'b10; e.cnt = 2;
         e.wdata = 64'h0000_0022_0000_0011; e.wmask = '1;
         sb.push_back(e); tick();
      end

      // Lane0 ALE with vaddr 0x1003: lane1 killed, enter DRAIN.
      @(negedge clk); clr();
      lane(0, 32'h2000, 32'h55, 1'b0, 16'h0200, 1'b0, 32'h1003);
      lane(1, 32'h2004, 32'h56, 1'b1, 16'h0, 1'b0, 32'h0);
      e = blank(); e.xf = 1'b1; e.ecode = 6'h09; e.bad_va = 32'h1003; e.va_err = 1'b1;
      e.era = 32'h2000; e.vppn = 19'h0; e.cnt = 2;
      sb.push_back(e); tick();

      // DRAIN drops a normal bundle.
      @(negedge clk); clr();
      lane(0, 32'h2008, 32'h57, 1'b0, 16'h0, 1'b0, 32'h0);
      lane(1, 32'h200C, 32'h58, 1'b0, 16'h0, 1'b0, 32'h0);
      e = blank(); e.cnt = 2; sb.push_back(e); tick();

      // Flush returns to RUN; its bundle is not taken.
      @(negedge clk); clr(); flush = 1'b1;
      lane(0, 32'h2010, 32'h59, 1'b0, 16'h0, 1'b0, 32'h0);
      e = blank(); e.cnt = 2; sb.push_back(e); tick();

      // Lane0 normal, lane1 ERTN: both commit, only lane0 writes, ertn pulse.
      @(negedge clk); clr();
      lane(0, 32'h3000, 32'h66, 1'b0, 16'h0, 1'b0, 32'h0);
      lane(1, 32'h3004, 32'h67, 1'b0, 16'h0, 1'b1, 32'h0);
      e = blank(); e.wreg = 2'b01; e.commit = 2'b11; e.ef = 1'b1; e.rec = 1'b0; e.cnt = 4;
      e.wdata = 64'h66; e.wmask = 64'hFFFF_FFFF;
      sb.push_back(e); tick();

      // Next bundle dropped, then flush.
      @(negedge clk); clr();
      lane(0, 32'h3008, 32'h68, 1'b0, 16'h0, 1'b0, 32'h0);
      e = blank(); e.cnt = 4; sb.push_back(e); tick();
      @(negedge clk); clr(); flush = 1'b1;
      e = blank(); e.cnt = 4; sb.push_back(e); tick();

      // Lane0 vector 0x0804: TLB refill, bad_va = pc, lane1 killed.
      @(negedge clk); clr();
      lane(0, 32'h8765_4320, 32'h70, 1'b0, 16'h0804, 1'b0, 32'hDEAD);
      lane(1, 32'h8765_4324, 32'h71, 1'b0, 16'h0, 1'b0, 32'h0);
      e = blank(); e.xf = 1'b1; e.ecode = 6'h3F; e.bad_va = 32'h8765_4320; e.va_err = 1'b1;
      e.tlb = 1'b1; e.refill = 1'b1; e.vppn = 19'h43B2A; e.era = 32'h8765_4320; e.cnt = 4;
      sb.push_back(e); tick();

      // Flush with a trapping bundle, from DRAIN and then from RUN: no pulse either time.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); clr(); flush = 1'b1;
         lane(0, 32'h4000, 32'h72, 1'b0, 16'h0020, 1'b0, 32'h0);
         e = blank(); e.cnt = 4; sb.push_back(e); tick();
      end

      // Still in RUN: a single normal lane commits.
      @(negedge clk); clr();
      lane(0, 32'h5000, 32'h88, 1'b0, 16'h0, 1'b0, 32'h0);
      e = blank(); e.wreg = 2'b01; e.commit = 2'b01; e.cnt = 5;
      e.wdata = 64'h88; e.wmask = 64'hFFFF_FFFF;
      sb.push_back(e); tick();

      // ADEM and ERTN on the same lane: exception wins.
      @(negedge clk); clr();
      lane(0, 32'h6000, 32'h90, 1'b0, 16'h0400, 1'b1, 32'h5FFF);
      lane(1, 32'h6004, 32'h91, 1'b0, 16'h0, 1'b0, 32'h0);
      e = blank(); e.xf = 1'b1; e.ecode = 6'h08; e.esub = 9'd1; e.bad_va = 32'h5FFF;
      e.va_err = 1'b1; e.vppn = 19'h2; e.era = 32'h6000; e.cnt = 5;
      sb.push_back(e); tick();

      // Reset during DRAIN.
      @(negedge clk); clr(); rst = 1'b1;
      lane(0, 32'h7000, 32'h92, 1'b1, 16'h0, 1'b0, 32'h0);
      lane(1, 32'h7004, 32'h93, 1'b1, 16'h0, 1'b0, 32'h0);
      e = blank(); sb.push_back(e); tick();

      // Back in RUN: lane1 alone.
      @(negedge clk); clr(); rst = 1'b0;
      lane(1, 32'h7004, 32'h99, 1'b0, 16'h0, 1'b0, 32'h0);
      e = blank(); e.wreg = 2'b10; e.commit = 2'b10; e.cnt = 1;
      e.wdata = 64'h0000_0099_0000_0000; e.wmask = 64'hFFFF_FFFF_0000_0000;
      sb.push_back(e); tick();

      // Trap on lane1 (INT): lane0 commits, era = lane1 pc.
      @(negedge clk); clr();
      lane(0, 32'h8000, 32'h77, 1'b0, 16'h0, 1'b0, 32'h0);
      lane(1, 32'h8004, 32'h78, 1'b0, 16'h0001, 1'b0, 32'h1234);
      e = blank(); e.wreg = 2'b01; e.commit = 2'b01; e.xf = 1'b1; e.era = 32'h8004; e.cnt = 2;
      e.wdata = 64'h77; e.wmask = 64'hFFFF_FFFF;
      sb.push_back(e); tick();

      // Stall right after the pulse: pulse lasts one cycle, data held.
      @(negedge clk); clr(); stall = 1'b1;
      lane(0, 32'h8008, 32'h79, 1'b0, 16'h0, 1'b0, 32'h0);
      e = blank(); e.wreg = 2'b01; e.cnt = 2;
      e.wdata = 64'h77; e.wmask = 64'hFFFF_FFFF;
      sb.push_back(e); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
